eim_regbank: RTL and testbench

//  Parametrised EIM slave register bank on the i.MX EIM multiplexed A/D bus.

---
 rtl/eim_regbank_if.sv | 29 ++
 rtl/eim_regbank.sv | 228 ++++++++++++++++++++++
 tb/tb_eim_regbank.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/eim_regbank_if.sv
// EIM multiplexed A/D bus bundle between the i.MX host and the register bank.
// The pads stay outside: the slave only sees the pad input value and returns
// a drive value plus a drive enable for the A/D tri-state buffers.
//   eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n : host strobes, active low
//   eim_da_in                                : A/D pad input
//   eim_da_out, eim_da_oe                    : A/D drive value / enable
//   eim_wait_n                               : wait request, active low
interface eim_regbank_if #(
  parameter int DATA_W = 16
) ();
  logic              eim_cs0_n;
  logic              eim_lba_n;
  logic              eim_wr_n;
  logic              eim_oe_n;
  logic [DATA_W-1:0] eim_da_in;
  logic [DATA_W-1:0] eim_da_out;
  logic              eim_da_oe;
  logic              eim_wait_n;

  modport master (
    output eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n, eim_da_in,
    input  eim_da_out, eim_da_oe, eim_wait_n
  );

  modport slave (
    input  eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n, eim_da_in,
    output eim_da_out, eim_da_oe, eim_wait_n
  );
endinterface

// File: rtl/eim_regbank.sv
// EIM slave register bank. Strobes and the A/D bus are synchronised into clk,
// the address is captured on LBA, and single/burst reads and writes are served
// with address auto-increment (mod DEPTH) and wait-state insertion on reads.
// The top NUM_RO addresses read the status_i words and reject writes.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   eim         : EIM bus (slave modport)
//   status_i    : read-only words, word k at address DEPTH-NUM_RO+k
//   reg_q       : RW registers, word n at [n*DATA_W +: DATA_W]
//   wr_stb      : 1-cycle pulse per committed RW write, with wr_addr/wr_data
//   rd_stb      : 1-cycle pulse per word loaded onto da_out
//   ro_wr_err   : 1-cycle pulse on a write to a read-only address
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no access; waiting for LBA fall with CS low
// ST_ADDR  | address captured; LBA rise picks write or read
// ST_RDWAIT| wait_n held low, first read word loaded
// ST_RDATA | drive bus while OE low; OE rise advances to the next word
// ST_WRITE | every WR rise commits one word and advances the address
module eim_regbank #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int NUM_RO      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_CYC    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  eim_regbank_if.slave                          eim,
  input  logic [NUM_RO*DATA_W-1:0]              status_i,
  output logic [(2**ADDR_W-NUM_RO)*DATA_W-1:0]  reg_q,
  output logic                                  wr_stb,
  output logic [ADDR_W-1:0]                     wr_addr,
  output logic [DATA_W-1:0]                     wr_data,
  output logic                                  rd_stb,
  output logic                                  ro_wr_err
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int RW_CNT = DEPTH - NUM_RO;
  localparam int RW_CNT_I = RW_CNT;
  localparam logic [ADDR_W:0] RW_LIM = RW_CNT_I[ADDR_W:0];
  localparam int CNT_W  = $clog2(WAIT_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_RDWAIT, ST_RDATA, ST_WRITE
  } state_t;

  // synchronisers
  logic [SYNC_STAGES-1:0] cs_sync, lba_sync, wr_sync, oe_sync;
  logic [DATA_W-1:0]      da_sync [SYNC_STAGES];
  logic                   s_cs, s_lba, s_wr, s_oe;
  logic [DATA_W-1:0]      s_da;
  logic                   d_cs, d_lba, d_wr, d_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= '1;
      lba_sync <= '1;
      wr_sync  <= '1;
      oe_sync  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) da_sync[i] <= '0;
      d_cs  <= 1'b1;
      d_lba <= 1'b1;
      d_wr  <= 1'b1;
      d_oe  <= 1'b1;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  eim.eim_cs0_n};
      lba_sync <= {lba_sync[SYNC_STAGES-2:0], eim.eim_lba_n};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0],  eim.eim_wr_n};
      oe_sync  <= {oe_sync[SYNC_STAGES-2:0],  eim.eim_oe_n};
      da_sync[0] <= eim.eim_da_in;
      for (int i = 1; i < SYNC_STAGES; i++) da_sync[i] <= da_sync[i-1];
      d_cs  <= s_cs;
      d_lba <= s_lba;
      d_wr  <= s_wr;
      d_oe  <= s_oe;
    end
  end

  assign s_cs  = cs_sync[SYNC_STAGES-1];
  assign s_lba = lba_sync[SYNC_STAGES-1];
  assign s_wr  = wr_sync[SYNC_STAGES-1];
  assign s_oe  = oe_sync[SYNC_STAGES-1];
  assign s_da  = da_sync[SYNC_STAGES-1];

  logic cs_rise, lba_fall, lba_rise, wr_rise, oe_rise;
  assign cs_rise  = s_cs  & ~d_cs;
  assign lba_fall = ~s_lba & d_lba;
  assign lba_rise = s_lba & ~d_lba;
  assign wr_rise  = s_wr  & ~d_wr;
  assign oe_rise  = s_oe  & ~d_oe;

  // register array and the unified read map (RW words, then status words)
  logic [DATA_W-1:0] regs     [RW_CNT];
  logic [DATA_W-1:0] word_arr [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (i < RW_CNT) begin : g_rw
      assign word_arr[i] = regs[i];
      assign reg_q[i*DATA_W +: DATA_W] = regs[i];
    end else begin : g_ro
      assign word_arr[i] = status_i[(i-RW_CNT)*DATA_W +: DATA_W];
    end
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_inc;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   da_out_q, da_out_d;
  logic                da_oe_q, da_oe_d;
  logic                wait_n_q, wait_n_d;
  logic                wr_stb_d, rd_stb_d, ro_err_d;
  logic                reg_we, addr_is_rw;

  assign addr_inc   = addr_q + 1'b1;
  assign addr_is_rw = ({1'b0, addr_q} < RW_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wcnt_q    <= '0;
      da_out_q  <= '0;
      da_oe_q   <= 1'b0;
      wait_n_q  <= 1'b1;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      ro_wr_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      da_out_q  <= da_out_d;
      da_oe_q   <= da_oe_d;
      wait_n_q  <= wait_n_d;
      wr_stb    <= wr_stb_d;
      rd_stb    <= rd_stb_d;
      ro_wr_err <= ro_err_d;
      if (reg_we) begin
        wr_addr <= addr_q;
        wr_data <= s_da;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RW_CNT; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[addr_q] <= s_da;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    da_out_d = da_out_q;
    da_oe_d  = 1'b0;
    wait_n_d = wait_n_q;
    wr_stb_d = 1'b0;
    rd_stb_d = 1'b0;
    ro_err_d = 1'b0;
    reg_we   = 1'b0;

    // A write strobe that lands together with CS release still commits.
    if (state_q == ST_WRITE && wr_rise) begin
      if (addr_is_rw) begin
        reg_we   = 1'b1;
        wr_stb_d = 1'b1;
      end else begin
        ro_err_d = 1'b1;
      end
      addr_d = addr_inc;
    end

    if (cs_rise) begin
      state_d  = ST_IDLE;
      wait_n_d = 1'b1;
    end else if (!s_cs && lba_fall) begin
      state_d  = ST_ADDR;
      addr_d   = s_da[ADDR_W-1:0];
      wait_n_d = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (lba_rise) begin
            if (!s_wr) begin
              state_d = ST_WRITE;
            end else begin
              state_d  = ST_RDWAIT;
              wait_n_d = 1'b0;
              wcnt_d   = CNT_W'(WAIT_CYC);
            end
          end
        end
        ST_RDWAIT: begin
          // first cycle in the wait window loads the word
          if (wcnt_q == CNT_W'(WAIT_CYC)) begin
            da_out_d = word_arr[addr_q];
            rd_stb_d = 1'b1;
          end
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == CNT_W'(1)) begin
            wait_n_d = 1'b1;
            state_d  = ST_RDATA;
          end
        end
        ST_RDATA: begin
          da_oe_d = ~s_oe;
          if (oe_rise) begin
            addr_d   = addr_inc;
            da_out_d = word_arr[addr_inc];
            rd_stb_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign eim.eim_da_out = da_out_q;
  assign eim.eim_da_oe  = da_oe_q;
  assign eim.eim_wait_n = wait_n_q;
endmodule

// File: tb/tb_eim_regbank.sv
module tb_eim_regbank;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  status_i = '0;
  logic [223:0] reg_q;
  logic         wr_stb, rd_stb, ro_wr_err;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0, rd_cnt = 0, ro_cnt = 0, wlo_cnt = 0;
  logic [3:0]  last_wa = '0;
  logic [15:0] last_wd = '0;

  eim_regbank_if #(.DATA_W(16)) bus ();

  eim_regbank dut (
    .clk(clk), .rst_n(rst_n), .eim(bus), .status_i(status_i), .reg_q(reg_q),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_stb(rd_stb), .ro_wr_err(ro_wr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (rd_stb) rd_cnt++;
    if (ro_wr_err) ro_cnt++;
    if (!bus.eim_wait_n) wlo_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3, input int n);
    logic [15:0] d [4];
    d = '{d0, d1, d2, d3};
    bus.eim_cs0_n = 1'b0; cyc(4);
    bus.eim_da_in = {12'hAB0, a};
    bus.eim_lba_n = 1'b0; cyc(5);
    bus.eim_wr_n = 1'b0; cyc(5);
    bus.eim_lba_n = 1'b1; cyc(5);
    for (int i = 0; i < n; i++) begin
      bus.eim_wr_n = 1'b0;
      bus.eim_da_in = d[i]; cyc(5);
      bus.eim_wr_n = 1'b1; cyc(5);
    end
    bus.eim_cs0_n = 1'b1; cyc(6);
  endtask

  task automatic host_read_start(input logic [3:0] a);
    bus.eim_cs0_n = 1'b0; cyc(4);
    bus.eim_da_in = {12'h5C0, a};
    bus.eim_lba_n = 1'b0; cyc(5);
    bus.eim_lba_n = 1'b1; cyc(8);
  endtask

  logic [223:0] exp_q;
  int w0, r0, o0, l0;

  initial begin
    bus.eim_cs0_n = 1'b1; bus.eim_lba_n = 1'b1;
    bus.eim_wr_n  = 1'b1; bus.eim_oe_n  = 1'b1;
    bus.eim_da_in = '0;
    cyc(3);
    chk("rst_da_oe", bus.eim_da_oe, 1'b0);
    chk("rst_wait_n", bus.eim_wait_n, 1'b1);
    chk("rst_da_out", bus.eim_da_out, 16'h0);
    chk("rst_reg_q", reg_q, 224'h0);
    rst_n = 1'b1; cyc(3);

    // 1: single write
    w0 = wr_cnt;
    host_write(4'd3, 16'h1234, 16'h0, 16'h0, 16'h0, 1);
    chk("t1_wr_cnt", wr_cnt - w0, 1);
    chk("t1_wr_addr", last_wa, 4'd3);
    chk("t1_wr_data", last_wd, 16'h1234);
    exp_q = '0; exp_q[3*16 +: 16] = 16'h1234;
    chk("t1_reg_q", reg_q, exp_q);

    // 2: single read
    l0 = wlo_cnt; r0 = rd_cnt;
    host_read_start(4'd3);
    chk("t2_wait_lo", wlo_cnt - l0, 2);
    chk("t2_wait_n", bus.eim_wait_n, 1'b1);
    chk("t2_oe_idle", bus.eim_da_oe, 1'b0);
    bus.eim_oe_n = 1'b0; cyc(5);
    chk("t2_da_oe", bus.eim_da_oe, 1'b1);
    chk("t2_da_out", bus.eim_da_out, 16'h1234);
    bus.eim_oe_n = 1'b1; bus.eim_cs0_n = 1'b1; cyc(6);
    chk("t2_da_oe_off", bus.eim_da_oe, 1'b0);
    chk("t2_rd_cnt", rd_cnt - r0, 1);

    // 3: burst write across the read-only words and the wrap
    w0 = wr_cnt; o0 = ro_cnt;
    host_write(4'd13, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4);
    chk("t3_wr_cnt", wr_cnt - w0, 2);
    chk("t3_ro_cnt", ro_cnt - o0, 2);
    chk("t3_last_wa", last_wa, 4'd0);
    chk("t3_last_wd", last_wd, 16'h4444);
    exp_q = '0;
    exp_q[3*16 +: 16]  = 16'h1234;
    exp_q[13*16 +: 16] = 16'h1111;
    exp_q[0 +: 16]     = 16'h4444;
    chk("t3_reg_q", reg_q, exp_q);

    // 4: burst read of the status words
    status_i = {16'hBEEF, 16'hCAFE};
    r0 = rd_cnt;
    host_read_start(4'd14);
    bus.eim_oe_n = 1'b0; cyc(5);
    chk("t4_beat0", bus.eim_da_out, 16'hCAFE);
    bus.eim_oe_n = 1'b1; cyc(5);
    bus.eim_oe_n = 1'b0; cyc(5);
    chk("t4_beat1", bus.eim_da_out, 16'hBEEF);
    chk("t4_da_oe", bus.eim_da_oe, 1'b1);
    bus.eim_oe_n = 1'b1; bus.eim_cs0_n = 1'b1; cyc(6);
    chk("t4_rd_cnt", rd_cnt - r0, 2);

    // 5: CS released mid-read, then a normal write
    host_read_start(4'd2);
    bus.eim_oe_n = 1'b0; cyc(5);
    chk("t5_da_oe_on", bus.eim_da_oe, 1'b1);
    bus.eim_cs0_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_da_oe_off", bus.eim_da_oe, 1'b0);
    chk("t5_wait_n", bus.eim_wait_n, 1'b1);
    @(negedge clk);
    bus.eim_oe_n = 1'b1; cyc(5);
    w0 = wr_cnt;
    host_write(4'd1, 16'hA5A5, 16'h0, 16'h0, 16'h0, 1);
    chk("t5_wr_cnt", wr_cnt - w0, 1);
    chk("t5_wr_addr", last_wa, 4'd1);
    chk("t5_wr_data", last_wd, 16'hA5A5);
    exp_q[1*16 +: 16] = 16'hA5A5;
    chk("t5_reg_q", reg_q, exp_q);

    // 6: reset during a write before the WR rise
    bus.eim_cs0_n = 1'b0; cyc(4);
    bus.eim_da_in = 16'h0005;
    bus.eim_lba_n = 1'b0; cyc(5);
    bus.eim_wr_n = 1'b0; cyc(5);
    bus.eim_lba_n = 1'b1; cyc(5);
    bus.eim_da_in = 16'h5555; cyc(5);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_reg_q", reg_q, 224'h0);
    chk("t6_da_oe", bus.eim_da_oe, 1'b0);
    chk("t6_wait_n", bus.eim_wait_n, 1'b1);
    chk("t6_da_out", bus.eim_da_out, 16'h0);
    chk("t6_pulses", {wr_stb, rd_stb, ro_wr_err}, 3'b000);
    cyc(3);
    rst_n = 1'b1; cyc(3);
    bus.eim_wr_n = 1'b1; cyc(5);
    bus.eim_cs0_n = 1'b1; cyc(6);
    chk("t6_wr_cnt", wr_cnt - w0, 0);
    chk("t6_reg_q_after", reg_q, 224'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
